// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only initiator.
// Phase constants name the four SCL quarters inside a bit slot.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] I2C_ADDR      = 7'h63;
  localparam logic       ACK_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: one-cycle tick every CLK_DIV clocks while en is high.
// Holding en low parks the counter at zero so each frame starts on a fresh quarter.
module i2c_qtick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C initiator: START, address byte, streamed data bytes, STOP.
// SCL/SDA are decoded from the state and quarter phase so async reset returns the pins to idle at once.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [6:0] ADDR      = I2C_ADDR,
  parameter logic       ACK_LEVEL = ACK_LEVEL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl,
  inout  wire        sda
);

  state_t     state, state_n;
  logic [1:0] phase, phase_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n;
  logic       ack_sample, ack_sample_n;
  logic       busy_n, done_n, nack_n, ready_n;
  logic       tick;
  logic       sda_out, sda_oe;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= Q0;
      bitcnt     <= '0;
      shreg      <= '0;
      ack_sample <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      din_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      ack_sample <= ack_sample_n;
      busy       <= busy_n;
      done       <= done_n;
      nack       <= nack_n;
      din_ready  <= ready_n;
    end
  end

  // Every state advances only on quarter ticks; the ACK decision is taken at the end of q3.
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    bitcnt_n     = bitcnt;
    shreg_n      = shreg;
    ack_sample_n = ack_sample;
    busy_n       = busy;
    done_n       = 1'b0;
    nack_n       = 1'b0;
    ready_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_n = {ADDR, 1'b0};
          busy_n  = 1'b1;
          phase_n = Q0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (phase == Q1) begin
            phase_n  = Q0;
            bitcnt_n = '0;
            state_n  = BIT;
          end else begin
            phase_n = phase + 2'd1;
          end
        end
      end
      BIT: begin
        if (tick) begin
          phase_n = phase + 2'd1;
          if (phase == Q3) begin
            shreg_n  = {shreg[6:0], 1'b0};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_n = ACK;
          end
        end
      end
      ACK: begin
        if (tick) begin
          phase_n = phase + 2'd1;
          if (phase == Q2) ack_sample_n = sda;
          if (phase == Q3) begin
            if (ack_sample != ACK_LEVEL) begin
              nack_n  = 1'b1;
              state_n = STOP;
            end else if (din_valid) begin
              ready_n  = 1'b1;
              shreg_n  = din;
              bitcnt_n = '0;
              state_n  = BIT;
            end else begin
              state_n = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          phase_n = phase + 2'd1;
          if (phase == Q3) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit and ACK slots hold SCL low for q0/q1 and high for q2/q3, i.e. SCL follows phase[1].
  always_comb begin
    scl     = 1'b1;
    sda_out = 1'b1;
    sda_oe  = 1'b1;
    case (state)
      START: sda_out = 1'b0;
      BIT: begin
        scl     = phase[1];
        sda_out = shreg[7];
      end
      ACK: begin
        scl    = phase[1];
        sda_oe = 1'b0;
      end
      STOP: begin
        scl     = (phase != Q0);
        sda_out = phase[1];
      end
      default: ;
    endcase
  end

  assign sda = sda_oe ? sda_out : 1'bz;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: a quarter-level waveform model checked every cycle,
// directed frames with literal expectations, random traffic, and an ACK_LEVEL=0 instance.
module tb_i2c_master_tx;

  localparam int         CLK_DIV = 4;
  localparam logic [6:0] ADDR_T  = 7'h63;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_ready, busy, done, nack, scl;
  wire        sda;
  logic       slave_oe = 1'b0, slave_val = 1'b1;
  assign sda = slave_oe ? slave_val : 1'bz;

  logic       start0 = 1'b0, din_valid0 = 1'b0;
  logic [7:0] din0 = 8'hFF;
  logic       din_ready0, busy0, done0, nack0, scl0;
  wire        sda0;
  logic       slave0_oe = 1'b0;
  int         fall0 = 0;
  assign sda0 = slave0_oe ? 1'b0 : 1'bz;

  i2c_master_tx #(.CLK_DIV(CLK_DIV), .ADDR(ADDR_T), .ACK_LEVEL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .busy(busy), .done(done), .nack(nack), .scl(scl), .sda(sda)
  );

  i2c_master_tx #(.CLK_DIV(CLK_DIV), .ADDR(ADDR_T), .ACK_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .din(din0), .din_valid(din_valid0),
    .din_ready(din_ready0), .busy(busy0), .done(done0), .nack(nack0), .scl(scl0), .sda(sda0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is a queue of quarters {scl, sda, released}, each CLK_DIV clocks long.
  typedef struct packed { logic scl; logic sda; logic rel; } qt_t;
  qt_t        mq[$];
  bit         mbusy = 0, mstop = 0;
  int         msub = 0, mslot = 0, cyc = 0, m_done_cyc = 0;
  bit [63:0]  ack_cfg = '1, ack_plan = '1;
  bit         rand_ack = 0;
  logic       e_scl = 1'b1, e_sda = 1'b1, e_rel = 1'b0, e_busy = 1'b0;
  logic       e_done = 1'b0, e_nack = 1'b0, e_ready = 1'b0;

  function automatic void push_q(input logic s, input logic d, input logic r, input int n);
    for (int i = 0; i < n; i++) mq.push_back(qt_t'({s, d, r}));
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      push_q(1'b0, b[i], 1'b0, 2);
      push_q(1'b1, b[i], 1'b0, 2);
    end
    push_q(1'b0, 1'b1, 1'b1, 2);
    push_q(1'b1, 1'b1, 1'b1, 2);
  endfunction

  function automatic void push_stop();
    push_q(1'b0, 1'b0, 1'b0, 1);
    push_q(1'b1, 1'b0, 1'b0, 1);
    push_q(1'b1, 1'b1, 1'b0, 2);
    mstop = 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mbusy = 0; mstop = 0; msub = 0; mslot = 0;
      e_done = 1'b0; e_nack = 1'b0; e_ready = 1'b0;
    end else begin
      cyc++;
      e_done = 1'b0; e_nack = 1'b0; e_ready = 1'b0;
      if (!mbusy) begin
        if (start) begin
          mbusy = 1; mstop = 0; msub = 0; mslot = 0;
          ack_plan = rand_ack ? ({$urandom, $urandom} | {$urandom, $urandom}) : ack_cfg;
          push_q(1'b1, 1'b0, 1'b0, 2);
          push_byte({ADDR_T, 1'b0});
        end
      end else begin
        msub++;
        if (msub == CLK_DIV) begin
          msub = 0;
          void'(mq.pop_front());
          if (mq.size() == 0) begin
            if (mstop) begin
              mbusy = 0; e_done = 1'b1; m_done_cyc = cyc;
            end else if (!ack_plan[mslot]) begin
              e_nack = 1'b1; push_stop();
            end else if (din_valid) begin
              e_ready = 1'b1; push_byte(din);
              if (mslot < 63) mslot++;
            end else begin
              push_stop();
            end
          end
        end
      end
    end
    e_busy = mbusy;
    if (mbusy) {e_scl, e_sda, e_rel} = mq[0];
    else       {e_scl, e_sda, e_rel} = 3'b110;
    slave_oe  = mbusy && e_rel;
    slave_val = ack_plan[mslot];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("scl", scl, e_scl);
      checkOutput("sda", sda, e_rel ? slave_val : e_sda);
      checkOutput("busy", busy, e_busy);
      checkOutput("done", done, e_done);
      checkOutput("nack", nack, e_nack);
      checkOutput("din_ready", din_ready, e_ready);
      checkOutput("done_nack_overlap", done & nack, 0);
    end
  end

  int done_cnt = 0, nack_cnt = 0, ready_cnt = 0, done_cyc = 0, nack_cyc = 0;
  int done0_cnt = 0, nack0_cnt = 0, ready0_cnt = 0, done0_cyc = 0;
  logic bits[$];
  logic bits0[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (done)       begin done_cnt++;  done_cyc  = cyc; end
      if (nack)       begin nack_cnt++;  nack_cyc  = cyc; end
      if (din_ready)  ready_cnt++;
      if (done0)      begin done0_cnt++; done0_cyc = cyc; end
      if (nack0)      nack0_cnt++;
      if (din_ready0) ready0_cnt++;
    end
  end

  always @(posedge scl)  bits.push_back(sda);
  always @(posedge scl0) bits0.push_back(sda0);

  // Responder for the ACK_LEVEL=0 instance: pulls SDA low through every 9th SCL low/high period.
  always @(negedge scl0 or negedge busy0) begin
    if (!busy0) fall0 = 0;
    else        fall0++;
    slave0_oe = (fall0 != 0) && (fall0 % 9 == 0);
  end

  // Byte source: either a directed list or random valid/data every cycle.
  logic [7:0] src_arr[8];
  int         src_taken = 0, src_first = 0, src_n = 0;
  bit         rand_src = 0, force_valid = 0;

  always @(negedge clk) begin
    if (din_ready) src_taken++;
    if (rand_src) begin
      din_valid = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
    end else if (src_taken - src_first < src_n) begin
      din_valid = 1'b1;
      din       = src_arr[src_taken - src_first];
    end else begin
      din_valid = force_valid;
      din       = 8'hEE;
    end
  end

  function automatic logic [7:0] get_byte(input bit which, input int base);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) begin
      if (which == 0 && base + i < bits.size())  v[7-i] = bits[base+i];
      if (which == 1 && base + i < bits0.size()) v[7-i] = bits0[base+i];
    end
    return v;
  endfunction

  task automatic applyStimulus(output int acc);
    @(posedge clk); #1;
    start = 1'b1;
    acc   = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({name, "_done_seen"}, 32'(done_cnt != base), 1);
  endtask

  int acc, d0, r0, n0, b0, n;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_scl", scl, 1);
    checkOutput("rst_sda", sda, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_nack", nack, 0);
    checkOutput("rst_ready", din_ready, 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_scl", scl, 1);

    // Address only, acknowledged, no data offered.
    d0 = done_cnt; r0 = ready_cnt; n0 = nack_cnt; b0 = bits.size();
    src_first = src_taken; src_n = 0;
    applyStimulus(acc);
    wait_done(d0, 400, "t1");
    checkOutput("t1_len", done_cyc - acc, 168);
    checkOutput("t1_model_len", m_done_cyc - acc, 168);
    checkOutput("t1_addr_bits", get_byte(0, b0), 8'hC6);
    checkOutput("t1_ready", ready_cnt - r0, 0);
    checkOutput("t1_nack", nack_cnt - n0, 0);

    // Two data bytes, all acknowledged.
    repeat (3) @(posedge clk);
    src_arr[0] = 8'hA5; src_arr[1] = 8'h3C;
    d0 = done_cnt; r0 = ready_cnt; b0 = bits.size();
    src_first = src_taken; src_n = 2;
    applyStimulus(acc);
    wait_done(d0, 800, "t2");
    checkOutput("t2_len", done_cyc - acc, 456);
    checkOutput("t2_addr_bits", get_byte(0, b0), 8'hC6);
    checkOutput("t2_byte0", get_byte(0, b0 + 9), 8'hA5);
    checkOutput("t2_byte1", get_byte(0, b0 + 18), 8'h3C);
    checkOutput("t2_ready", ready_cnt - r0, 2);

    // Address NACKed while data is waiting.
    repeat (3) @(posedge clk);
    ack_cfg[0] = 1'b0; force_valid = 1;
    d0 = done_cnt; r0 = ready_cnt; n0 = nack_cnt;
    src_first = src_taken; src_n = 0;
    applyStimulus(acc);
    wait_done(d0, 400, "t3");
    checkOutput("t3_nack", nack_cnt - n0, 1);
    checkOutput("t3_ready", ready_cnt - r0, 0);
    checkOutput("t3_done_after_nack", done_cyc - nack_cyc, 16);
    checkOutput("t3_nack_at", nack_cyc - acc, 152);
    ack_cfg[0] = 1'b1; force_valid = 0;

    // Second start mid-frame is dropped; a start after done runs a new frame.
    repeat (3) @(posedge clk);
    d0 = done_cnt;
    applyStimulus(acc);
    repeat (60) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, 400, "t4a");
    repeat (200) @(posedge clk);
    #1;
    checkOutput("t4_single_done", done_cnt - d0, 1);
    checkOutput("t4_idle", busy, 0);
    applyStimulus(acc);
    wait_done(d0 + 1, 400, "t4b");
    checkOutput("t4_second_len", done_cyc - acc, 168);

    // Reset during bit 3 of a data byte.
    repeat (3) @(posedge clk);
    src_arr[0] = 8'h5A;
    src_first = src_taken; src_n = 1;
    applyStimulus(acc);
    n = 0;
    while (cyc < acc + 205 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5_scl", scl, 1);
    checkOutput("t5_sda", sda, 1);
    checkOutput("t5_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    src_first = src_taken; src_n = 0;
    d0 = done_cnt; n0 = nack_cnt; b0 = bits.size();
    applyStimulus(acc);
    wait_done(d0, 400, "t5");
    checkOutput("t5_len", done_cyc - acc, 168);
    checkOutput("t5_addr_bits", get_byte(0, b0), 8'hC6);
    checkOutput("t5_nack", nack_cnt - n0, 0);

    // Random traffic: random start pulses, valid/data and ACK plans.
    d0 = done_cnt;
    rand_src = 1; rand_ack = 1;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; rand_src = 0; rand_ack = 0;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rand_idle", busy, 0);
    checkOutput("rand_frames", 32'((done_cnt - d0) > 5), 1);

    // ACK_LEVEL=0 instance: responder pulls SDA low, one 0xFF data byte.
    repeat (3) @(posedge clk);
    d0 = done0_cnt; r0 = ready0_cnt; n0 = nack0_cnt; b0 = bits0.size();
    din0 = 8'hFF; din_valid0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1; acc = cyc + 1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (ready0_cnt == r0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    din_valid0 = 1'b0;
    n = 0;
    while (done0_cnt == d0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("t6_done", done0_cnt - d0, 1);
    checkOutput("t6_len", done0_cyc - acc, 312);
    checkOutput("t6_addr_bits", get_byte(1, b0), 8'hC6);
    checkOutput("t6_data_bits", get_byte(1, b0 + 9), 8'hFF);
    checkOutput("t6_ack_level", {bits0[b0 + 8], bits0[b0 + 17]}, 2'b00);
    checkOutput("t6_ready", ready0_cnt - r0, 1);
    checkOutput("t6_nack", nack0_cnt - n0, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
